step_counter: RTL and testbench
===============================

STEP_COUNTER -- requirements
Module: step_counter

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the counter, limit and load width.
REQ-002 Parameter STEP_W, default 4, SHALL set the step-size width.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on rising edge.
REQ-004 rst  input  1  SHALL be the synchronous, active-high reset.
REQ-005 en  input  1  SHALL enable one count step per cycle when high.
REQ-006 load  input  1  SHALL request a synchronous load of load_val.
REQ-007 load_val  input  WIDTH  SHALL be the value to load.
REQ-008 up  input  1  SHALL select the direction: 1 = increment, 0 = decrement.
REQ-009 step  input  STEP_W  SHALL be the unsigned amount added or subtracted per enabled cycle.
REQ-010 limit  input  WIDTH  SHALL be the inclusive upper bound; the lower bound is fixed at 0.
REQ-011 mode  input  2  SHALL select boundary behaviour: 00 wrap, 01 saturate, 10 one-shot, 11 reserved (behaves as wrap).
REQ-012 count  output  WIDTH  SHALL be the registered counter value.
REQ-013 tc  output  1  SHALL be a registered one-cycle terminal-count pulse.
REQ-014 halted  output  1  SHALL be high while the one-shot state machine is in HALT.

Function
REQ-015 Priority SHALL be rst > load > en; with en low and no load, count, state and halted SHALL hold and tc SHALL be 0.
REQ-016 Latency SHALL be 1 cycle: inputs sampled at edge N are reflected on count and tc after edge N.
REQ-017 Arithmetic SHALL use WIDTH+1 bits internally; step SHALL be zero-extended.
REQ-018 Up step: if count+step <= limit, next = count+step and tc = 0.
REQ-019 Up overflow (count+step > limit):
- wrap: next = count+step-(limit+1)
- saturate: next = limit
- one-shot: next = limit, enter HALT
- tc = 1 in all modes
REQ-020 Down step: if step <= count, next = count-step and tc = 0.
REQ-021 Down underflow (step > count):
- wrap: next = count+(limit+1)-step
- saturate: next = 0
- one-shot: next = 0, enter HALT
- tc = 1 in all modes
REQ-022 Exactly reaching limit (up) or 0 (down) SHALL NOT be an overflow and SHALL NOT pulse tc.
REQ-023 step = 0 SHALL hold count and SHALL NOT pulse tc.
REQ-024 Saturate mode already at the bound with a nonzero step outward SHALL hold count and SHALL pulse tc every such cycle.
REQ-025 Wrap correctness SHALL be guaranteed only for step <= limit+1; larger steps SHALL produce the same formula result, and the result is not range-checked.
REQ-026 If count > limit at an enabled up step (limit lowered mid-run), it SHALL be treated as overflow per REQ-019.
REQ-027 load SHALL set count = min(load_val, limit), clear tc, and return the FSM to RUN.
REQ-028 The FSM SHALL have two states, RUN and HALT:
- RUN -> HALT on a one-shot boundary event
- HALT -> RUN only on load or rst
- in HALT, en SHALL be ignored and count SHALL hold
REQ-029 A mode change while in HALT SHALL NOT leave HALT.
REQ-030 Simultaneous load and en: load SHALL win and no step SHALL be applied in that cycle.

Reset
REQ-031 On rst high at a clock edge: count = 0, tc = 0, halted = 0, FSM = RUN.
REQ-032 rst mid-operation SHALL override load and en in that same cycle.
REQ-033 rst SHALL be the only reset; no asynchronous or power-on state SHALL be relied on.

Structure
REQ-034 The mode encodings (WRAP, SAT, ONESHOT) and the FSM state encodings (RUN, HALT) SHALL live in the shared package step_counter_pkg.
REQ-035 The next-value computation (REQ-017 to REQ-026) SHALL be the combinational sub-module step_counter_next.
REQ-036 The top module SHALL hold only the registers, the FSM and the priority logic.

Verification
REQ-037 Reset then wrap: WIDTH=8, limit=9, mode=00, up=1, step=3, en held for 4 cycles -> count 3, 6, 9, 2; tc high only on the cycle count becomes 2.
REQ-038 Saturate down: load 5, mode=01, up=0, step=4, en for 3 cycles -> count 1, 0, 0; tc = 0, 1, 1.
REQ-039 One-shot: load 250, limit=255, mode=10, step=5, en held -> count 255 with tc and halted =1; further en -> count holds, tc = 0; load 7 -> count 7, halted = 0.
REQ-040 Priority: load=1 (load_val=200, limit=100) with en=1 -> count 100, tc = 0; the same cycle with rst=1 -> count 0.
REQ-041 Boundary no-pulse: limit=10, count 8, step=2 up -> count 10, tc = 0; step=0 -> count holds, tc = 0.
REQ-042 Limit lowered: count 50, limit changed to 20, wrap, up, step=1 -> count 30, tc = 1.

Source files
------------

// File: rtl/step_counter_pkg.sv
// step_counter_pkg: encodings shared by the step counter slice.
//   mode_e  : boundary behaviour selected by the 2-bit mode input.
//   state_e : RUN / HALT states of the one-shot state machine.
package step_counter_pkg;

   typedef enum logic [1:0] {
      MODE_WRAP    = 2'b00,
      MODE_SAT     = 2'b01,
      MODE_ONESHOT = 2'b10,
      MODE_RSVD    = 2'b11   // decoded as wrap
   } mode_e;

   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_HALT = 1'b1
   } state_e;

endpackage

// File: rtl/step_counter_if.sv
// step_counter_if: control/status bundle of the step counter.
//   en, load, load_val, up, step, limit, mode : driven by the master
//   count, tc, halted                          : driven by the counter (slave)
interface step_counter_if #(
   parameter int WIDTH  = 8,
   parameter int STEP_W = 4
) ();
   logic              en;
   logic              load;
   logic [WIDTH-1:0]  load_val;
   logic              up;
   logic [STEP_W-1:0] step;
   logic [WIDTH-1:0]  limit;
   logic [1:0]        mode;
   logic [WIDTH-1:0]  count;
   logic              tc;
   logic              halted;

   modport master (
      output en, load, load_val, up, step, limit, mode,
      input  count, tc, halted
   );

   modport slave (
      input  en, load, load_val, up, step, limit, mode,
      output count, tc, halted
   );
endinterface

// File: rtl/step_counter_next.sv
// step_counter_next: combinational next-value computation.
//   count, limit, step, up, mode : current value and step controls
//   nxt      : value the counter takes on an enabled step
//   tc       : boundary crossed (overflow above limit / underflow below 0)
//   halt_req : boundary crossed in one-shot mode
// All arithmetic is done one bit wider than the counter so count+step and
// limit+1 never wrap.
module step_counter_next
   import step_counter_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int STEP_W = 4
) (
   input  logic [WIDTH-1:0]  count,
   input  logic [WIDTH-1:0]  limit,
   input  logic [STEP_W-1:0] step,
   input  logic              up,
   input  mode_e             mode,
   output logic [WIDTH-1:0]  nxt,
   output logic              tc,
   output logic              halt_req
);
   localparam int W1 = WIDTH + 1;

   logic [W1-1:0] c_x, l_x, s_x, span, sum;

   assign c_x  = {1'b0, count};
   assign l_x  = {1'b0, limit};
   assign s_x  = W1'(step);
   assign span = l_x + W1'(1);
   assign sum  = c_x + s_x;

   always_comb begin
      nxt      = count;
      tc       = 1'b0;
      halt_req = 1'b0;
      // a zero step is a no-op, even at or beyond a bound
      if (step != '0) begin
         if (up) begin
            // count already above a lowered limit also lands here
            if (sum > l_x) begin
               tc = 1'b1;
               case (mode)
                  MODE_SAT:     nxt = limit;
                  MODE_ONESHOT: begin nxt = limit; halt_req = 1'b1; end
                  default:      nxt = WIDTH'(sum - span);
               endcase
            end else begin
               nxt = sum[WIDTH-1:0];
            end
         end else begin
            if (s_x <= c_x) begin
               nxt = WIDTH'(c_x - s_x);
            end else begin
               tc = 1'b1;
               case (mode)
                  MODE_SAT:     nxt = '0;
                  MODE_ONESHOT: begin nxt = '0; halt_req = 1'b1; end
                  // oversized steps are not range-checked; result is the
                  // plain formula truncated to WIDTH
                  default:      nxt = WIDTH'(c_x + span - s_x);
               endcase
            end
         end
      end
   end

endmodule

// File: rtl/step_counter.sv
// step_counter: up/down counter with programmable step, upper limit and
// wrap / saturate / one-shot boundary behaviour.
//   clk : clock, rising edge
//   rst : synchronous active-high reset
//   sc  : step_counter_if.slave (controls in; count, tc, halted out)
// Priority per cycle is rst > load > en. Outputs are registered; halted
// reflects the registered FSM state.
module step_counter
   import step_counter_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int STEP_W = 4
) (
   input  logic          clk,
   input  logic          rst,
   step_counter_if.slave sc
);
   logic [WIDTH-1:0] count_q, count_d, nxt, load_clip;
   logic             tc_q, tc_d, nxt_tc, halt_req;
   state_e           state_q, state_d;

   step_counter_next #(.WIDTH(WIDTH), .STEP_W(STEP_W)) u_next (
      .count    (count_q),
      .limit    (sc.limit),
      .step     (sc.step),
      .up       (sc.up),
      .mode     (mode_e'(sc.mode)),
      .nxt      (nxt),
      .tc       (nxt_tc),
      .halt_req (halt_req)
   );

   assign load_clip = (sc.load_val > sc.limit) ? sc.limit : sc.load_val;

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      tc_d    = 1'b0;
      if (sc.load) begin
         count_d = load_clip;
         state_d = ST_RUN;
      end else if (sc.en && state_q == ST_RUN) begin
         count_d = nxt;
         tc_d    = nxt_tc;
         if (halt_req) state_d = ST_HALT;
      end
      // en in HALT is ignored: count holds, tc stays low
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
         tc_q    <= 1'b0;
         state_q <= ST_RUN;
      end else begin
         count_q <= count_d;
         tc_q    <= tc_d;
         state_q <= state_d;
      end
   end

   assign sc.count  = count_q;
   assign sc.tc     = tc_q;
   assign sc.halted = (state_q == ST_HALT);

endmodule

// File: tb/tb_step_counter.sv
// tb_step_counter: directed scenarios plus randomized traffic against a
// behavioural model of the counter rules.
module tb_step_counter;
   localparam int WIDTH  = 8;
   localparam int STEP_W = 4;
   localparam int MOD    = 1 << WIDTH;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   n_cmp = 0;
   int   n_err = 0;

   // behavioural model state
   int m_cnt  = 0;
   bit m_tc   = 0;
   bit m_halt = 0;

   step_counter_if #(.WIDTH(WIDTH), .STEP_W(STEP_W)) sc_if ();

   step_counter #(.WIDTH(WIDTH), .STEP_W(STEP_W)) dut (
      .clk (clk),
      .rst (rst),
      .sc  (sc_if)
   );

   always #5 clk = ~clk;

   task automatic drive(input bit en, input bit load, input int lval, input bit up,
                        input int step, input int lim, input int mode);
      sc_if.en       = en;
      sc_if.load     = load;
      sc_if.load_val = WIDTH'(lval);
      sc_if.up       = up;
      sc_if.step     = STEP_W'(step);
      sc_if.limit    = WIDTH'(lim);
      sc_if.mode     = 2'(mode);
   endtask

   // advance one clock; model follows the counter rules on the sampled inputs
   task automatic tick();
      int lim, s, md, nc, v;
      bit ntc, nh;
      lim = int'(sc_if.limit); s = int'(sc_if.step); md = int'(sc_if.mode);
      nc = m_cnt; ntc = 0; nh = m_halt;
      if (rst) begin
         nc = 0; nh = 0;
      end else if (sc_if.load) begin
         v  = int'(sc_if.load_val);
         nc = (v > lim) ? lim : v;
         nh = 0;
      end else if (sc_if.en && !m_halt && s != 0) begin
         if (sc_if.up) begin
            if (m_cnt + s > lim) begin
               ntc = 1;
               if (md == 1)      nc = lim;
               else if (md == 2) begin nc = lim; nh = 1; end
               else              nc = (m_cnt + s - (lim + 1)) % MOD;
            end else nc = m_cnt + s;
         end else begin
            if (s > m_cnt) begin
               ntc = 1;
               if (md == 1)      nc = 0;
               else if (md == 2) begin nc = 0; nh = 1; end
               else              nc = (((m_cnt + lim + 1 - s) % MOD) + MOD) % MOD;
            end else nc = m_cnt - s;
         end
      end
      @(posedge clk);
      m_cnt = nc; m_tc = ntc; m_halt = nh;
      #1;
   endtask

   task automatic test_reset();
      drive(0, 0, 0, 1, 0, 255, 0);
      rst = 1'b1; tick(); rst = 1'b0;
      n_cmp++;
      if (sc_if.count !== 8'd0 || sc_if.tc !== 1'b0 || sc_if.halted !== 1'b0) begin
         n_err++;
         $display("FAIL reset: count=%0d tc=%b halted=%b, want 0/0/0", sc_if.count, sc_if.tc, sc_if.halted);
      end
   endtask

   task automatic test_wrap();
      int exp_c[4] = '{3, 6, 9, 2};
      bit exp_t[4] = '{0, 0, 0, 1};
      rst = 1'b1; tick(); rst = 1'b0;
      drive(1, 0, 0, 1, 3, 9, 0);
      for (int i = 0; i < 4; i++) begin
         tick();
         n_cmp++;
         if (sc_if.count !== WIDTH'(exp_c[i]) || sc_if.tc !== exp_t[i]) begin
            n_err++;
            $display("FAIL wrap[%0d]: count=%0d tc=%b, want %0d/%b", i, sc_if.count, sc_if.tc, exp_c[i], exp_t[i]);
         end
      end
      drive(0, 0, 0, 1, 3, 9, 0);
      tick();
      n_cmp++;
      if (sc_if.count !== 8'd2 || sc_if.tc !== 1'b0) begin
         n_err++;
         $display("FAIL en_low_hold: count=%0d tc=%b, want 2/0", sc_if.count, sc_if.tc);
      end
   endtask

   task automatic test_sat_down();
      int exp_c[3] = '{1, 0, 0};
      bit exp_t[3] = '{0, 1, 1};
      drive(0, 1, 5, 0, 4, 255, 1); tick();
      n_cmp++;
      if (sc_if.count !== 8'd5 || sc_if.tc !== 1'b0) begin
         n_err++;
         $display("FAIL sat_load: count=%0d tc=%b, want 5/0", sc_if.count, sc_if.tc);
      end
      drive(1, 0, 0, 0, 4, 255, 1);
      for (int i = 0; i < 3; i++) begin
         tick();
         n_cmp++;
         if (sc_if.count !== WIDTH'(exp_c[i]) || sc_if.tc !== exp_t[i]) begin
            n_err++;
            $display("FAIL sat_down[%0d]: count=%0d tc=%b, want %0d/%b", i, sc_if.count, sc_if.tc, exp_c[i], exp_t[i]);
         end
      end
   endtask

   task automatic test_oneshot();
      int exp_c[3] = '{255, 255, 255};
      bit exp_t[3] = '{0, 1, 0};
      bit exp_h[3] = '{0, 1, 1};
      drive(0, 1, 250, 1, 5, 255, 2); tick();
      drive(1, 0, 0, 1, 5, 255, 2);
      for (int i = 0; i < 3; i++) begin
         tick();
         n_cmp++;
         if (sc_if.count !== WIDTH'(exp_c[i]) || sc_if.tc !== exp_t[i] || sc_if.halted !== exp_h[i]) begin
            n_err++;
            $display("FAIL oneshot[%0d]: count=%0d tc=%b halted=%b, want %0d/%b/%b",
                     i, sc_if.count, sc_if.tc, sc_if.halted, exp_c[i], exp_t[i], exp_h[i]);
         end
      end
      // mode change while halted must not release HALT
      drive(1, 0, 0, 0, 5, 255, 0); tick();
      n_cmp++;
      if (sc_if.count !== 8'd255 || sc_if.halted !== 1'b1 || sc_if.tc !== 1'b0) begin
         n_err++;
         $display("FAIL halt_mode_chg: count=%0d tc=%b halted=%b, want 255/0/1", sc_if.count, sc_if.tc, sc_if.halted);
      end
      drive(0, 1, 7, 1, 5, 255, 2); tick();
      n_cmp++;
      if (sc_if.count !== 8'd7 || sc_if.halted !== 1'b0) begin
         n_err++;
         $display("FAIL oneshot_reload: count=%0d halted=%b, want 7/0", sc_if.count, sc_if.halted);
      end
   endtask

   task automatic test_priority();
      drive(1, 1, 200, 1, 3, 100, 0); tick();
      n_cmp++;
      if (sc_if.count !== 8'd100 || sc_if.tc !== 1'b0) begin
         n_err++;
         $display("FAIL load_over_en: count=%0d tc=%b, want 100/0", sc_if.count, sc_if.tc);
      end
      rst = 1'b1; tick(); rst = 1'b0;
      n_cmp++;
      if (sc_if.count !== 8'd0 || sc_if.tc !== 1'b0) begin
         n_err++;
         $display("FAIL rst_over_load: count=%0d tc=%b, want 0/0", sc_if.count, sc_if.tc);
      end
   endtask

   task automatic test_boundary();
      drive(0, 1, 8, 1, 2, 10, 0); tick();
      drive(1, 0, 0, 1, 2, 10, 0); tick();
      n_cmp++;
      if (sc_if.count !== 8'd10 || sc_if.tc !== 1'b0) begin
         n_err++;
         $display("FAIL exact_limit: count=%0d tc=%b, want 10/0", sc_if.count, sc_if.tc);
      end
      drive(1, 0, 0, 1, 0, 10, 0); tick();
      n_cmp++;
      if (sc_if.count !== 8'd10 || sc_if.tc !== 1'b0) begin
         n_err++;
         $display("FAIL step_zero: count=%0d tc=%b, want 10/0", sc_if.count, sc_if.tc);
      end
      // saturate at the bound keeps pulsing tc
      drive(1, 0, 0, 1, 3, 10, 1);
      for (int i = 0; i < 2; i++) begin
         tick();
         n_cmp++;
         if (sc_if.count !== 8'd10 || sc_if.tc !== 1'b1) begin
            n_err++;
            $display("FAIL sat_at_bound[%0d]: count=%0d tc=%b, want 10/1", i, sc_if.count, sc_if.tc);
         end
      end
   endtask

   task automatic test_limit_lowered();
      drive(0, 1, 50, 1, 1, 255, 0); tick();
      drive(1, 0, 0, 1, 1, 20, 0); tick();
      n_cmp++;
      if (sc_if.count !== 8'd30 || sc_if.tc !== 1'b1) begin
         n_err++;
         $display("FAIL limit_lowered: count=%0d tc=%b, want 30/1", sc_if.count, sc_if.tc);
      end
   endtask

   task automatic test_random();
      int lim;
      lim = 200;
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(15) == 0) lim = $urandom_range(255);
         rst = ($urandom_range(49) == 0);
         drive($urandom_range(3) != 0, $urandom_range(11) == 0, $urandom_range(255),
               $urandom_range(1), $urandom_range(15), lim, $urandom_range(3));
         tick();
         n_cmp++;
         if (sc_if.count !== WIDTH'(m_cnt) || sc_if.tc !== m_tc || sc_if.halted !== m_halt) begin
            n_err++;
            $display("FAIL random[%0d]: count=%0d tc=%b halted=%b, want %0d/%b/%b",
                     i, sc_if.count, sc_if.tc, sc_if.halted, m_cnt, m_tc, m_halt);
         end
      end
      rst = 1'b0;
   endtask

   initial begin
      drive(0, 0, 0, 1, 0, 255, 0);
      test_reset();
      test_wrap();
      test_sat_down();
      test_oneshot();
      test_priority();
      test_boundary();
      test_limit_lowered();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
